aui_lane_checker: RTL and testbench
===================================

# aui_lane_checker

Receive-side lane checker that consumes the 16 parallel lanes produced by the AUI generator. It compares every lane against a delayed copy of the word fed to the generator and runs a per-lane SEARCH/LOCKED state machine. It also keeps saturating per-lane error counters. It is the bring-up and BER monitor directly downstream of the generator in the AUI test path.

## Interface
- DATA_WIDTH, 64, width of each lane word and of the reference word
- NUMBER_LANES, 16, number of lanes checked
- REF_DELAY, 1, cycles between the reference input and the matching lane data; legal range 1..8
- LOCK_THRESH, 8, consecutive matching words needed to enter LOCKED
- UNLOCK_THRESH, 4, consecutive mismatching words in LOCKED needed to return to SEARCH
- ERR_CNT_WIDTH, 16, width of each error counter
- clk  input  1  single clock; all logic on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- i_ref_data  input  DATA_WIDTH  word presented to the generator this cycle
- i_valid  input  1  i_ref_data is valid this cycle
- rx_lane  input  DATA_WIDTH x NUMBER_LANES (unpacked array)  lane words from the generator
- i_clear_cnt  input  1  synchronous clear of all error counters
- o_lane_locked  output  NUMBER_LANES  per-lane LOCKED indication
- o_all_locked  output  1  all lanes LOCKED
- o_err_cnt  output  ERR_CNT_WIDTH x NUMBER_LANES (unpacked array)  per-lane saturating error count
- o_err_flag  output  1  one-cycle pulse when any LOCKED lane mismatched in the previous compare

## Operation
- Reference path: i_ref_data and i_valid pass through a REF_DELAY-deep shift register. Its output (ref_d, valid_d) aligns with rx_lane.
- A compare happens only when valid_d=1. When valid_d=0, all FSM state, run counters and error counters hold.
- mismatch[i] = (rx_lane[i] != ref_d).
- Per-lane FSM, independent per lane, with states SEARCH (reset state) and LOCKED:
  - SEARCH: a match increments the run counter and a mismatch zeroes it. When the run counter reaches LOCK_THRESH, the lane goes to LOCKED and the run counter zeroes.
  - LOCKED: a mismatch increments the miss counter and a match zeroes it. When the miss counter reaches UNLOCK_THRESH, the lane goes to SEARCH and both counters zero.
- Error counting applies only to mismatches while the lane is LOCKED, including the mismatch that causes unlock. Each such event adds the increment to o_err_cnt[i]. The increment is defined under Configuration.
- Counter arithmetic: ERR_CNT_WIDTH+1-bit sum. The counter saturates at all-ones and never wraps.
- i_clear_cnt zeroes all o_err_cnt. When an error occurs in the same cycle as the clear, the clear wins and the counter is 0 afterwards. i_clear_cnt does not affect FSM state.
- o_all_locked = AND of o_lane_locked, registered alongside it.

## Timing
- Reset (rst_n=0, asynchronous) clears the following:
  - delay line data and valid
  - all FSMs to SEARCH and all run/miss counters to 0
  - o_lane_locked=0, o_all_locked=0, o_err_cnt=0, o_err_flag=0
- Reset asserted mid-operation takes effect immediately. After release, lanes must relock from scratch.
- Latency: i_ref_data sampled at edge k is compared with rx_lane sampled at edge k+REF_DELAY. All resulting outputs are registered and visible after that edge.
- A lane locks after the edge that samples its LOCK_THRESH-th consecutive valid match, so o_lane_locked rises after that edge.
- o_err_flag is high for exactly the cycle following an edge that counted any error. It is not held.
- Gaps in i_valid do not break a match or mismatch run.

## Configuration
- AUI_CHK_BIT_ERR_EN defined: the increment is popcount(rx_lane[i] ^ ref_d), i.e. the counters count bit errors, computed in the same cycle.
- AUI_CHK_BIT_ERR_EN undefined: the increment is 1 per mismatching word, i.e. the counters count word errors.
- Saturation, clear priority and all other behaviour are identical in both builds.

## Test plan
- Reset, then 8 valid cycles of matching data, REF_DELAY=1 -> o_lane_locked=16'hFFFF and o_all_locked=1 after the 8th compare edge; all o_err_cnt=0.
- Locked lanes; flip bits [3:0] of lane 5 for one word -> o_err_cnt[5]=1 (word build) or 4 (bit build), o_err_flag pulses one cycle, lane 5 stays LOCKED.
- Corrupt lane 2 for 4 consecutive valid words -> o_lane_locked[2] falls after the 4th, o_err_cnt[2]=4 (word build), lane 2 relocks after 8 further clean words.
- ERR_CNT_WIDTH=4, 20 corrupt words with relock between bursts -> o_err_cnt saturates at 15 and never wraps. Assert i_clear_cnt in the same cycle as an error -> counter reads 0.
- Interleave i_valid=0 cycles with garbage on rx_lane during SEARCH -> no state change; lock still occurs after exactly 8 valid matches.
- Assert rst_n=0 mid-lock for one cycle -> all outputs are 0 immediately, and relock takes 8 valid matches.

Source files
------------

// File: rtl/aui_lane_checker.sv
// Receive-side lane checker for the AUI test path: per-lane SEARCH/LOCKED tracking and saturating error counters.
// Define AUI_CHK_BIT_ERR_EN to count bit errors (popcount) instead of word errors.
module aui_lane_checker #(
  parameter int DATA_WIDTH    = 64,
  parameter int NUMBER_LANES  = 16,
  parameter int REF_DELAY     = 1,
  parameter int LOCK_THRESH   = 8,
  parameter int UNLOCK_THRESH = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    i_ref_data,
  input  logic                     i_valid,
  input  logic [DATA_WIDTH-1:0]    rx_lane [NUMBER_LANES],
  input  logic                     i_clear_cnt,
  output logic [NUMBER_LANES-1:0]  o_lane_locked,
  output logic                     o_all_locked,
  output logic [ERR_CNT_WIDTH-1:0] o_err_cnt [NUMBER_LANES],
  output logic                     o_err_flag
);

  localparam int RUN_W  = $clog2(LOCK_THRESH + 1);
  localparam int MISS_W = $clog2(UNLOCK_THRESH + 1);
  localparam int INC_W  = $clog2(DATA_WIDTH + 1);
  localparam int SUM_W  = ((ERR_CNT_WIDTH > INC_W) ? ERR_CNT_WIDTH : INC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({ERR_CNT_WIDTH{1'b1}});

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} lane_state_t;

  logic [DATA_WIDTH-1:0]    ref_sr [REF_DELAY];
  logic [REF_DELAY-1:0]     valid_sr;
  logic [DATA_WIDTH-1:0]    ref_d;
  logic                     valid_d;

  lane_state_t              state_q [NUMBER_LANES];
  lane_state_t              state_d [NUMBER_LANES];
  logic [RUN_W-1:0]         run_q   [NUMBER_LANES];
  logic [RUN_W-1:0]         run_d   [NUMBER_LANES];
  logic [MISS_W-1:0]        miss_q  [NUMBER_LANES];
  logic [MISS_W-1:0]        miss_d  [NUMBER_LANES];
  logic [DATA_WIDTH-1:0]    diff    [NUMBER_LANES];
  logic [INC_W-1:0]         inc     [NUMBER_LANES];
  logic [SUM_W-1:0]         sum     [NUMBER_LANES];
  logic [ERR_CNT_WIDTH-1:0] cnt_d   [NUMBER_LANES];
  logic [NUMBER_LANES-1:0]  err_event;
  logic [NUMBER_LANES-1:0]  locked_d;

  assign ref_d   = ref_sr[REF_DELAY-1];
  assign valid_d = valid_sr[REF_DELAY-1];

  // Reference delay line aligns the generator input with the returned lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REF_DELAY; i++) ref_sr[i] <= '0;
      valid_sr <= '0;
    end else begin
      ref_sr[0]   <= i_ref_data;
      valid_sr[0] <= i_valid;
      for (int i = 1; i < REF_DELAY; i++) begin
        ref_sr[i]   <= ref_sr[i-1];
        valid_sr[i] <= valid_sr[i-1];
      end
    end
  end

  always_comb begin
    err_event = '0;
    locked_d  = '0;
    for (int i = 0; i < NUMBER_LANES; i++) begin
      state_d[i] = state_q[i];
      run_d[i]   = run_q[i];
      miss_d[i]  = miss_q[i];
      cnt_d[i]   = o_err_cnt[i];
      diff[i]    = rx_lane[i] ^ ref_d;
`ifdef AUI_CHK_BIT_ERR_EN
      inc[i] = '0;
      for (int b = 0; b < DATA_WIDTH; b++) inc[i] = inc[i] + INC_W'(diff[i][b]);
`else
      inc[i] = INC_W'(1);
`endif
      if (valid_d) begin
        unique case (state_q[i])
          SEARCH: begin
            if (|diff[i]) begin
              run_d[i] = '0;
            end else if (run_q[i] == RUN_W'(LOCK_THRESH - 1)) begin
              state_d[i] = LOCKED;
              run_d[i]   = '0;
            end else begin
              run_d[i] = run_q[i] + RUN_W'(1);
            end
          end
          LOCKED: begin
            if (|diff[i]) begin
              err_event[i] = 1'b1;
              if (miss_q[i] == MISS_W'(UNLOCK_THRESH - 1)) begin
                state_d[i] = SEARCH;
                miss_d[i]  = '0;
                run_d[i]   = '0;
              end else begin
                miss_d[i] = miss_q[i] + MISS_W'(1);
              end
            end else begin
              miss_d[i] = '0;
            end
          end
          default: state_d[i] = SEARCH;
        endcase
      end
      // Widened sum so a full-word popcount cannot wrap past the saturation check.
      sum[i] = SUM_W'(o_err_cnt[i]) + SUM_W'(inc[i]);
      if (err_event[i]) cnt_d[i] = (sum[i] > CNT_MAX) ? CNT_MAX[ERR_CNT_WIDTH-1:0] : sum[i][ERR_CNT_WIDTH-1:0];
      if (i_clear_cnt) cnt_d[i] = '0;
      locked_d[i] = (state_d[i] == LOCKED);
    end
  end

  always_comb begin
    for (int i = 0; i < NUMBER_LANES; i++) o_lane_locked[i] = (state_q[i] == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUMBER_LANES; i++) begin
        state_q[i]   <= SEARCH;
        run_q[i]     <= '0;
        miss_q[i]    <= '0;
        o_err_cnt[i] <= '0;
      end
      o_all_locked <= 1'b0;
      o_err_flag   <= 1'b0;
    end else begin
      for (int i = 0; i < NUMBER_LANES; i++) begin
        state_q[i]   <= state_d[i];
        run_q[i]     <= run_d[i];
        miss_q[i]    <= miss_d[i];
        o_err_cnt[i] <= cnt_d[i];
      end
      o_all_locked <= &locked_d;
      o_err_flag   <= |err_event;
    end
  end

endmodule

// File: tb/tb_aui_lane_checker.sv
// Randomised self-checking bench for aui_lane_checker against a behavioural lane model.
module tb_aui_lane_checker;
  localparam int DW = 64, NL = 16, RD = 1, LT = 8, UT = 4, EW = 4;
  localparam int CMAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] i_ref_data = '0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] rx_lane [NL];
  logic          i_clear_cnt = 1'b0;
  logic [NL-1:0] o_lane_locked;
  logic          o_all_locked;
  logic [EW-1:0] o_err_cnt [NL];
  logic          o_err_flag;

  int checks = 0, errors = 0;
  logic [DW-1:0] ref_q [$];
  bit            val_q [$];
  bit            m_lk [NL];
  int            m_run [NL], m_miss [NL], m_cnt [NL];
  bit            m_flag, m_cmp;
  logic [DW-1:0] mask [NL];

  aui_lane_checker #(.DATA_WIDTH(DW), .NUMBER_LANES(NL), .REF_DELAY(RD), .LOCK_THRESH(LT),
                     .UNLOCK_THRESH(UT), .ERR_CNT_WIDTH(EW)) dut (
    .clk(clk), .rst_n(rst_n), .i_ref_data(i_ref_data), .i_valid(i_valid), .rx_lane(rx_lane),
    .i_clear_cnt(i_clear_cnt), .o_lane_locked(o_lane_locked), .o_all_locked(o_all_locked),
    .o_err_cnt(o_err_cnt), .o_err_flag(o_err_flag));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void modelReset();
    ref_q.delete();
    val_q.delete();
    for (int i = 0; i < RD; i++) begin
      ref_q.push_back('0);
      val_q.push_back(1'b0);
    end
    for (int i = 0; i < NL; i++) begin
      m_lk[i] = 0; m_run[i] = 0; m_miss[i] = 0; m_cnt[i] = 0;
    end
    m_flag = 0;
  endfunction

  // Model of one rising edge, using the inputs the bench is currently driving.
  function automatic void modelEdge();
    bit any = 0;
    int inc;
    m_cmp = val_q[0];
    if (val_q[0]) begin
      for (int i = 0; i < NL; i++) begin
        bit mm = (rx_lane[i] != ref_q[0]);
`ifdef AUI_CHK_BIT_ERR_EN
        inc = $countones(rx_lane[i] ^ ref_q[0]);
`else
        inc = 1;
`endif
        if (!m_lk[i]) begin
          m_run[i] = mm ? 0 : m_run[i] + 1;
          if (m_run[i] == LT) begin m_lk[i] = 1; m_run[i] = 0; end
        end else if (mm) begin
          any = 1;
          m_cnt[i] = (m_cnt[i] + inc > CMAX) ? CMAX : m_cnt[i] + inc;
          m_miss[i]++;
          if (m_miss[i] == UT) begin m_lk[i] = 0; m_miss[i] = 0; m_run[i] = 0; end
        end else begin
          m_miss[i] = 0;
        end
      end
    end
    if (i_clear_cnt) for (int i = 0; i < NL; i++) m_cnt[i] = 0;
    m_flag = any;
    void'(ref_q.pop_front());
    void'(val_q.pop_front());
    ref_q.push_back(i_ref_data);
    val_q.push_back(i_valid);
  endfunction

  task automatic checkAll(input string tag);
    logic [63:0] exp_lk = '0, exp_cnt = '0, got_cnt = '0;
    for (int i = 0; i < NL; i++) begin
      exp_lk[i]          = m_lk[i];
      exp_cnt[i*EW +: EW] = EW'(m_cnt[i]);
      got_cnt[i*EW +: EW] = o_err_cnt[i];
    end
    checkOutput({tag, "_locked"}, 64'(o_lane_locked), exp_lk);
    checkOutput({tag, "_all"}, 64'(o_all_locked), 64'(&exp_lk[NL-1:0]));
    checkOutput({tag, "_cnt"}, got_cnt, exp_cnt);
    checkOutput({tag, "_flag"}, 64'(o_err_flag), 64'(m_flag));
  endtask

  task automatic applyStimulus(input bit valid, input bit clear);
    i_valid     = valid;
    i_clear_cnt = clear;
    i_ref_data  = {$urandom, $urandom};
    for (int i = 0; i < NL; i++)
      rx_lane[i] = val_q[0] ? (ref_q[0] ^ mask[i]) : {$urandom, $urandom};
    @(posedge clk);
    modelEdge();
    #1 checkAll("step");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < NL; i++) begin mask[i] = '0; rx_lane[i] = '0; end
    modelReset();
    repeat (2) @(posedge clk);
    #1 checkAll("reset");
    rst_n = 1'b1;

    for (int k = 1; k <= LT + 1; k++) begin
      applyStimulus(1, 0);
      if (k == LT) checkOutput("pre_lock", 64'(o_lane_locked), 64'h0);
    end
    checkOutput("lock_all", 64'(o_lane_locked), 64'hFFFF);
    checkOutput("all_locked", 64'(o_all_locked), 64'h1);

    mask[5] = 64'hF;
    applyStimulus(1, 0);
    mask[5] = '0;
`ifdef AUI_CHK_BIT_ERR_EN
    checkOutput("lane5_cnt", 64'(o_err_cnt[5]), 64'd4);
`else
    checkOutput("lane5_cnt", 64'(o_err_cnt[5]), 64'd1);
`endif
    checkOutput("lane5_flag", 64'(o_err_flag), 64'h1);
    checkOutput("lane5_lock", 64'(o_lane_locked[5]), 64'h1);
    applyStimulus(1, 0);
    checkOutput("lane5_flag_off", 64'(o_err_flag), 64'h0);

    mask[2] = 64'h1;
    for (int k = 1; k <= UT; k++) begin
      applyStimulus(1, 0);
      if (k == UT - 1) checkOutput("lane2_hold", 64'(o_lane_locked[2]), 64'h1);
    end
    mask[2] = '0;
    checkOutput("lane2_unlock", 64'(o_lane_locked[2]), 64'h0);
    checkOutput("lane2_cnt", 64'(o_err_cnt[2]), 64'd4);
    for (int k = 1; k <= LT; k++) begin
      applyStimulus(1, 0);
      if (k == LT - 1) checkOutput("lane2_norelock", 64'(o_lane_locked[2]), 64'h0);
    end
    checkOutput("lane2_relock", 64'(o_lane_locked[2]), 64'h1);

    for (int k = 0; k < 20; k++) begin
      mask[7] = 64'h100;
      applyStimulus(1, 0);
      mask[7] = '0;
      applyStimulus(1, 0);
    end
    checkOutput("lane7_sat", 64'(o_err_cnt[7]), 64'd15);
    mask[7] = 64'h100;
    applyStimulus(1, 1);
    mask[7] = '0;
    checkOutput("clear_wins", 64'(o_err_cnt[7]), 64'd0);

    rst_n = 1'b0;
    #2 modelReset();
    checkAll("midreset");
    checkOutput("midreset_lock", 64'(o_lane_locked), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    n = 0;
    for (int k = 0; k < 200 && n < LT; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), 0);
      if (m_cmp) n++;
      checkOutput("gap_lock", 64'(o_lane_locked), (n >= LT) ? 64'hFFFF : 64'h0);
    end
    checkOutput("gap_reached", 64'(n), 64'(LT));

    for (int k = 0; k < 1500; k++) begin
      int rate = (k < 750) ? 15 : 3;
      for (int i = 0; i < NL; i++)
        mask[i] = ($urandom_range(0, rate) == 0) ? ({$urandom, $urandom} | 64'h1) : '0;
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
